// File: rtl/readssr_spi_responder.sv
// SPI mode-0 slave that streams a locally written NUM_BYTES snapshot buffer on MISO
// while the master holds readssr_req; SCLK and REQ are oversampled in the clk domain.
module readssr_spi_responder #(
    parameter int unsigned NUM_BYTES   = 35,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       readssr_req,
    output logic       readssr_ack,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_blocked,
    output logic       busy,
    output logic       xfer_done
);

    localparam int unsigned IDX_W = $clog2(NUM_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BYTES - 1);
    localparam logic [5:0]       ADDR_LIMIT = 6'(NUM_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] req_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic                   sclk_prev_q;
    logic                   sclk_rise_q;
    logic                   sclk_fall_q;
    logic [7:0]             mem_q [NUM_BYTES];
    logic [7:0]             shreg_q, shreg_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]       byte_idx_q, byte_idx_d;
    logic                   xfer_done_q, xfer_done_d;
    logic                   wr_blocked_q, wr_blocked_d;

    logic             req_s;
    logic             sclk_s;
    logic             wr_ok_s;
    logic             last_bit_s;
    logic [IDX_W-1:0] next_idx_s;
    logic             unused_mosi_s;

    assign req_s         = req_sync_q[SYNC_STAGES-1];
    assign sclk_s        = sclk_sync_q[SYNC_STAGES-1];
    assign wr_ok_s       = wr_en && (state_q == IDLE) && (wr_addr < ADDR_LIMIT);
    assign wr_blocked_d  = wr_en && !wr_ok_s;
    assign last_bit_s    = (bit_cnt_q == 3'd7) && (byte_idx_q == LAST_IDX);
    assign next_idx_s    = byte_idx_q + IDX_W'(1);
    assign unused_mosi_s = mosi;

    // Input synchronizers; strobes are registered so each edge yields exactly one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_sync_q  <= '0;
            sclk_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
        end else begin
            req_sync_q  <= {req_sync_q[SYNC_STAGES-2:0], readssr_req};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            sclk_prev_q <= sclk_s;
            sclk_rise_q <= sclk_s && !sclk_prev_q;
            sclk_fall_q <= !sclk_s && sclk_prev_q;
        end
    end

    // Snapshot buffer: deliberately not reset so contents survive rst
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a released request always wins over SCLK activity
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_s) state_d = SEND;
                else       state_d = IDLE;
            end
            SEND: begin
                if (!req_s)                         state_d = IDLE;
                else if (sclk_rise_q && last_bit_s) state_d = DONE;
                else                                state_d = SEND;
            end
            DONE: begin
                if (!req_s) state_d = IDLE;
                else        state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        readssr_ack = 1'b0;
        miso_oe     = 1'b0;
        miso        = 1'b0;
        busy        = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
            end
            SEND: begin
                readssr_ack = 1'b1;
                miso_oe     = 1'b1;
                miso        = shreg_q[7];
                busy        = 1'b1;
            end
            DONE: begin
                readssr_ack = 1'b1;
                miso_oe     = 1'b1;
                busy        = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Shift datapath: count on rise, shift on fall, fetch next byte on the fall after the 8th rise
    always_comb begin
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        byte_idx_d  = byte_idx_q;
        xfer_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    bit_cnt_d  = 3'd0;
                    byte_idx_d = '0;
                    shreg_d    = mem_q[0];
                end else begin
                    shreg_d = shreg_q;
                end
            end
            SEND: begin
                if (!req_s) begin
                    shreg_d = shreg_q;
                end else if (sclk_rise_q) begin
                    bit_cnt_d   = bit_cnt_q + 3'd1;
                    xfer_done_d = last_bit_s;
                end else if (sclk_fall_q) begin
                    if ((bit_cnt_q == 3'd0) && (byte_idx_q != LAST_IDX)) begin
                        shreg_d    = mem_q[next_idx_s];
                        byte_idx_d = next_idx_s;
                    end else begin
                        shreg_d = {shreg_q[6:0], 1'b0};
                    end
                end else begin
                    shreg_d = shreg_q;
                end
            end
            default: begin
                shreg_d = shreg_q;
            end
        endcase
    end

    // Datapath and pulse output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            byte_idx_q   <= '0;
            xfer_done_q  <= 1'b0;
            wr_blocked_q <= 1'b0;
        end else begin
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_idx_q   <= byte_idx_d;
            xfer_done_q  <= xfer_done_d;
            wr_blocked_q <= wr_blocked_d;
        end
    end

    assign xfer_done  = xfer_done_q;
    assign wr_blocked = wr_blocked_q;

endmodule

// File: tb/tb_readssr_spi_responder.sv
// Bench for readssr_spi_responder: acts as the SPI master and the local core,
// comparing captured MISO bytes against a queue of expected buffer contents.
module tb_readssr_spi_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       readssr_req = 1'b0;
    logic       readssr_ack;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic       wr_en = 1'b0;
    logic [5:0] wr_addr = 6'd0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_blocked;
    logic       busy;
    logic       xfer_done;

    int         n_cmp = 0;
    int         n_err = 0;
    int         done_cnt = 0;
    logic [7:0] mem_m [35];
    logic [7:0] sb_q [$];

    readssr_spi_responder #(.NUM_BYTES(35), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .readssr_req (readssr_req),
        .readssr_ack (readssr_ack),
        .sclk        (sclk),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_blocked  (wr_blocked),
        .busy        (busy),
        .xfer_done   (xfer_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (xfer_done) done_cnt++;
    end

    task automatic wr(input logic [5:0] a, input logic [7:0] d, output logic blk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        blk = wr_blocked;
        wr_en = 1'b0;
    endtask

    task automatic sclk_cycle(input int lo, input int hi, output logic b);
        repeat (lo) @(negedge clk);
        b = miso;
        sclk = 1'b1;
        repeat (hi) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic raise_req(output int lat);
        readssr_req = 1'b1;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (readssr_ack) begin lat = k; break; end
        end
    endtask

    task automatic drop_req(output int lat);
        readssr_req = 1'b0;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (!readssr_ack && !miso_oe) begin lat = k; break; end
        end
    endtask

    // Clock out n bytes from byte 0; each expected byte is queued as its first bit is clocked
    task automatic run_bytes(input int n, input int lo, input int hi, input int gap);
        logic [7:0] got, exp;
        logic b;
        for (int i = 0; i < n; i++) begin
            sb_q.push_back(mem_m[i]);
            got = 8'h00;
            for (int j = 0; j < 8; j++) begin
                sclk_cycle((j == 0 && i != 0) ? lo + gap : lo, hi, b);
                got = {got[6:0], b};
            end
            exp = sb_q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL byte%0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({readssr_ack, miso, miso_oe, busy, wr_blocked, xfer_done} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {readssr_ack, miso, miso_oe, busy, wr_blocked, xfer_done});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle_miso;
        logic b;
        for (int i = 0; i < 6; i++) begin
            sclk_cycle(6, 6, b);
            n_cmp++;
            if ({b, miso_oe, busy, readssr_ack} !== 4'b0) begin
                n_err++;
                $display("FAIL idle_miso: got %b expected 0000", {b, miso_oe, busy, readssr_ack});
            end
        end
    endtask

    task automatic test_load_buffer;
        logic blk;
        for (int i = 0; i < 35; i++) begin
            mem_m[i] = 8'hA0 + 8'(i);
            wr(6'(i), mem_m[i], blk);
            n_cmp++;
            if (blk !== 1'b0) begin
                n_err++;
                $display("FAIL load_wr%0d: wr_blocked %b expected 0", i, blk);
            end
        end
        wr(6'd40, 8'h77, blk);
        n_cmp++;
        if (blk !== 1'b1) begin
            n_err++;
            $display("FAIL wr_addr40: wr_blocked %b expected 1", blk);
        end
        @(negedge clk);
        n_cmp++;
        if (wr_blocked !== 1'b0) begin
            n_err++;
            $display("FAIL wr_blocked_pulse: wr_blocked %b expected 0", wr_blocked);
        end
    endtask

    task automatic test_full_transfer;
        int lat;
        logic blk;
        logic b;
        raise_req(lat);
        n_cmp++;
        if (lat != 3 || miso !== mem_m[0][7]) begin
            n_err++;
            $display("FAIL ack_latency: got %0d miso %b expected 3 miso %b", lat, miso, mem_m[0][7]);
        end
        wr(6'd3, 8'h55, blk);
        n_cmp++;
        if (blk !== 1'b1) begin
            n_err++;
            $display("FAIL wr_in_send: wr_blocked %b expected 1", blk);
        end
        run_bytes(35, 6, 6, 0);
        n_cmp++;
        if (done_cnt != 1 || busy !== 1'b1 || miso !== 1'b0 || miso_oe !== 1'b1) begin
            n_err++;
            $display("FAIL done_state: done_cnt %0d busy %b miso %b oe %b expected 1 1 0 1",
                     done_cnt, busy, miso, miso_oe);
        end
        sclk_cycle(6, 6, b);
        repeat (6) @(negedge clk);
        n_cmp++;
        if (done_cnt != 1 || b !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL done_ignores_sclk: done_cnt %0d miso %b busy %b expected 1 0 1",
                     done_cnt, b, busy);
        end
        drop_req(lat);
        n_cmp++;
        if (lat != 3 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL ack_fall_latency: got %0d busy %b expected 3 0", lat, busy);
        end
    endtask

    task automatic test_abort;
        int lat;
        int base;
        logic b;
        base = done_cnt;
        raise_req(lat);
        run_bytes(12, 6, 6, 0);
        for (int i = 0; i < 4; i++) sclk_cycle(6, 6, b);
        drop_req(lat);
        n_cmp++;
        if (lat < 1 || lat > 4) begin
            n_err++;
            $display("FAIL abort_latency: got %0d expected 1..4", lat);
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (done_cnt != base || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_done: done_cnt %0d busy %b expected %0d 0", done_cnt, busy, base);
        end
        raise_req(lat);
        n_cmp++;
        if (lat != 3) begin
            n_err++;
            $display("FAIL abort_rereq: latency %0d expected 3", lat);
        end
        run_bytes(2, 6, 6, 0);
        drop_req(lat);
    endtask

    task automatic test_reset_mid_send;
        int lat;
        logic b;
        raise_req(lat);
        run_bytes(5, 6, 6, 0);
        for (int i = 0; i < 5; i++) sclk_cycle(6, 6, b);
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if ({readssr_ack, miso, miso_oe, busy, wr_blocked, xfer_done} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_mid_send: got %b expected 000000",
                     {readssr_ack, miso, miso_oe, busy, wr_blocked, xfer_done});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (readssr_ack) begin lat = k; break; end
        end
        n_cmp++;
        if (lat != 3 || miso !== mem_m[0][7]) begin
            n_err++;
            $display("FAIL reset_reack: latency %0d miso %b expected 3 %b", lat, miso, mem_m[0][7]);
        end
        run_bytes(3, 6, 6, 0);
        drop_req(lat);
    endtask

    task automatic test_stretched;
        int lat;
        int base;
        base = done_cnt;
        raise_req(lat);
        run_bytes(35, 5, 5, 1000);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (done_cnt != base + 1) begin
            n_err++;
            $display("FAIL stretched_done: done_cnt %0d expected %0d", done_cnt, base + 1);
        end
        drop_req(lat);
        n_cmp++;
        if (lat != 3) begin
            n_err++;
            $display("FAIL stretched_release: latency %0d expected 3", lat);
        end
    endtask

    initial begin
        test_reset();
        test_idle_miso();
        test_load_buffer();
        test_full_transfer();
        test_abort();
        test_reset_mid_send();
        test_stretched();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/readssr_spi_responder.md
# readssr_spi_responder

Fabric SPI slave answering the `readssr_req`/`readssr_ack` handshake of the SPI-master readout block. It transfers a 35-byte snapshot buffer, loaded by the local core, out on MISO as an SPI mode-0 slave, one bit per master SCLK edge. It sits on the sensor/peripheral FPGA, between the core's register-write port and the inter-board SPI pins. It uses no hard SPI IP: SCLK and REQ are oversampled in the `clk` domain.

## Interface
- `NUM_BYTES`, 35: bytes sent per request; the buffer depth.
- `SYNC_STAGES`, 2: flops in each input synchronizer (minimum 2).
- `clk`  in  1  system clock. All state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `readssr_req`  in  1  request from the master; asynchronous to `clk`.
- `readssr_ack`  out  1  acknowledge; high from the accept point until the request is released.
- `sclk`  in  1  SPI clock from the master (mode 0, idle low).
- `mosi`  in  1  master data; ignored (the master sends dummy 0x00).
- `miso`  out  1  serial data, MSB first.
- `miso_oe`  out  1  MISO output enable; the top level tristates MISO when this is 0.
- `wr_en`  in  1  buffer write strobe.
- `wr_addr`  in  6  buffer byte index.
- `wr_data`  in  8  buffer write data.
- `wr_blocked`  out  1  one-cycle pulse when a `wr_en` write is dropped.
- `busy`  out  1  high in every state except IDLE.
- `xfer_done`  out  1  one-cycle pulse when byte NUM_BYTES-1, bit 0 has been sampled.

## Operation
- Synchronizers:
  - `readssr_req` and `sclk` each pass through a SYNC_STAGES flop chain.
  - `sclk` also gets one more flop for edge detection, giving `sclk_rise` and `sclk_fall` single-cycle strobes.
- Buffer: NUM_BYTES x 8 bits.
  - A write happens only when `wr_en`=1, state is IDLE and `wr_addr` < NUM_BYTES.
  - Any other `wr_en`=1 cycle drops the write and pulses `wr_blocked`.
  - The buffer is not reset.
- State IDLE:
  - Outputs: `readssr_ack`=0, `miso_oe`=0, `miso`=0.
  - On synced req=1: clear `byte_idx` and `bit_cnt`, load `shreg` from buf[0], go to SEND.
- State SEND:
  - `readssr_ack`=1, `miso_oe`=1, `miso`=`shreg[7]`.
  - On `sclk_rise`: `bit_cnt`++.
    - If `bit_cnt` was 7 and `byte_idx`=NUM_BYTES-1: go to DONE and pulse `xfer_done`.
  - On `sclk_fall`: shift `shreg` left.
    - If `bit_cnt` is 0 after a wrap (byte boundary), load `shreg` from buf[`byte_idx`+1] and increment `byte_idx`.
    - Equivalent rule: the byte advance happens on the fall that follows the 8th rise.
  - If synced req=0: abort to IDLE. Drop ack and `miso_oe` on the next cycle; no `xfer_done`.
- State DONE:
  - `readssr_ack`=1, `miso_oe`=1, `miso`=0.
  - SCLK edges are ignored.
  - When synced req=0, go to IDLE.
- Counter widths:
  - `bit_cnt`: 3 bits, wraps 7→0.
  - `byte_idx`: `$clog2(NUM_BYTES)` bits, never exceeds NUM_BYTES-1.
- Simultaneous events:
  - `sclk_rise` and req-drop in the same cycle: the abort wins.
  - `wr_en` in the same cycle as the IDLE→SEND transition: the write completes (state is still IDLE), and buf[0] is loaded with the pre-write value if `wr_addr`=0.
- `rst` mid-transfer: everything returns to IDLE immediately. Outputs take their reset values: `readssr_ack`=0, `miso`=0, `miso_oe`=0, `busy`=0, `wr_blocked`=0, `xfer_done`=0. Buffer contents are kept.

## Timing
- REQ rise to `readssr_ack`=1: SYNC_STAGES+1 `clk` cycles.
- MISO carries bit 7 of buf[0] from the ack-assert cycle onward.
- SCLK pin edge to internal strobe: SYNC_STAGES+1 cycles.
- `miso` updates 1 cycle after `sclk_fall`, so pin fall to MISO change is SYNC_STAGES+2 cycles.
- Constraint: SCLK high time and low time are each ≥ SYNC_STAGES+3 `clk` periods. With 2 stages and a 48 MHz `clk`, SCLK ≤ 4.8 MHz.
- Master-side bytes have no gaps requirement. Arbitrary idle time between bytes is tolerated, since state only advances on edges.
- REQ fall to `readssr_ack`=0: SYNC_STAGES+1 cycles.
- A new request is accepted only after ack has been seen low for one cycle (IDLE).

## Test plan
- Full transfer:
  - Stimulus: write buf[i]=0xA0+i for i=0..34; raise REQ; run 280 SCLK cycles at clk/12; drop REQ.
  - Required response: the captured MISO bytes are 0xA0..0xC2 in order; `xfer_done` pulses exactly once after the 280th rise; ack falls 3 cycles after REQ falls.
- Write blocking:
  - Stimulus: write 0x55 to address 3 while in SEND.
  - Required response: `wr_blocked` pulses and byte 3 still reads 0xA3. A write to address 40 in IDLE also pulses `wr_blocked`.
- Abort:
  - Stimulus: drop REQ after 100 SCLK cycles.
  - Required response: ack=0 and `miso_oe`=0 within 4 cycles; no `xfer_done`. The next request restarts from byte 0 (0xA0).
- Reset mid-SEND:
  - Stimulus: assert `rst` asynchronously at bit 45.
  - Required response: all outputs go low immediately. After release with REQ still high, ack reasserts 3 cycles later and the transfer restarts from byte 0.
- Stretched clock:
  - Stimulus: SCLK with a 1000-cycle gap after every byte, plus minimum-width phases of 5 clk cycles.
  - Required response: the data is identical to the full-transfer case.
- Idle MISO:
  - Stimulus: toggle SCLK with REQ low.
  - Required response: `miso`=0, `miso_oe`=0, `busy`=0, and no state change.
